// File: rtl/divider_seq_appr.sv
// Sequential signed restoring divider: 2*BIT-bit dividend / BIT-bit divisor -> BIT-bit quotient and remainder.
// Define APPROX_DIV_EN to skip the last TRUNC iterations and OR-fill the low quotient bits.
module divider_seq_appr #(
  parameter int BIT   = 16,
  parameter int TRUNC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*BIT-1:0]   dividend,
  input  logic [BIT-1:0]     divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT-1:0]     quotient,
  output logic [BIT-1:0]     remainder,
  output logic               div_zero,
  output logic               ovf
);

`ifdef APPROX_DIV_EN
  localparam int N = BIT - TRUNC;
`else
  localparam int N = BIT;
`endif
  localparam int CW = $clog2(BIT);

  localparam logic [BIT-1:0] Q_MAX = {1'b0, {(BIT-1){1'b1}}};
  localparam logic [BIT-1:0] Q_MIN = {1'b1, {(BIT-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2*BIT-1:0] op_dvd;
  logic [BIT-1:0]  op_dvs;
  logic [BIT:0]    dvs_mag;
  logic [BIT:0]    rem_r;
  logic [BIT-1:0]  low_r;
  logic [BIT-1:0]  quo_r;
  logic            q_neg, r_neg, dz_r, ovf_r;

  // Operand magnitudes are one bit wider than the operands so the most-negative value is representable.
  logic [2*BIT:0]   dvd_ext, dvd_abs;
  logic [BIT:0]     dvs_ext, dvs_abs;
  logic [2*BIT+1:0] dvd_cmp, lim_pos, lim_neg;
  logic             dvs_is_zero, ovf_cond;

  assign dvd_ext     = {op_dvd[2*BIT-1], op_dvd};
  assign dvs_ext     = {op_dvs[BIT-1], op_dvs};
  assign dvd_abs     = dvd_ext[2*BIT] ? -dvd_ext : dvd_ext;
  assign dvs_abs     = dvs_ext[BIT]   ? -dvs_ext : dvs_ext;
  assign dvs_is_zero = (op_dvs == '0);

  // Quotient magnitude reaches 2^(BIT-1) (pos) or 2^(BIT-1)+1 (neg) exactly when |D| crosses these limits.
  assign dvd_cmp  = (2*BIT+2)'(dvd_abs);
  assign lim_pos  = (2*BIT+2)'({dvs_abs, {(BIT-1){1'b0}}});
  assign lim_neg  = lim_pos + (2*BIT+2)'(dvs_abs);
  assign ovf_cond = !dvs_is_zero &&
                    ((op_dvd[2*BIT-1] ^ op_dvs[BIT-1]) ? (dvd_cmp >= lim_neg) : (dvd_cmp >= lim_pos));

  // One restoring step: shift in the next dividend bit and subtract if it fits.
  logic [BIT+1:0] trial;
  logic [BIT:0]   diff;
  logic           ge;

  assign trial = {rem_r, low_r[BIT-1]};
  assign ge    = (trial >= {1'b0, dvs_mag});
  assign diff  = trial[BIT:0] - dvs_mag;

  logic [BIT-1:0] q_mag, q_fin, r_fin;

  always_comb begin
`ifdef APPROX_DIV_EN
    q_mag = {quo_r[N-1:0], {TRUNC{|rem_r}}};
    r_fin = '0;
`else
    q_mag = quo_r;
    r_fin = r_neg ? -rem_r[BIT-1:0] : rem_r[BIT-1:0];
`endif
    q_fin = q_neg ? -q_mag : q_mag;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = PREP;
      end
      PREP: state_nxt = ITER;
      ITER: if (cnt == CW'(N-1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: working registers are left unreset; the FSM loads them before use, so only control and outputs need reset.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (in_valid) begin
        op_dvd <= dividend;
        op_dvs <= divisor;
      end
      PREP: begin
        q_neg   <= op_dvd[2*BIT-1] ^ op_dvs[BIT-1];
        r_neg   <= op_dvd[2*BIT-1];
        dz_r    <= dvs_is_zero;
        ovf_r   <= ovf_cond;
        dvs_mag <= dvs_abs;
        rem_r   <= dvd_abs[2*BIT:BIT];
        low_r   <= dvd_abs[BIT-1:0];
        quo_r   <= '0;
        cnt     <= '0;
      end
      ITER: begin
        rem_r <= ge ? diff : trial[BIT:0];
        low_r <= {low_r[BIT-2:0], 1'b0};
        quo_r <= {quo_r[BIT-2:0], ge};
        cnt   <= cnt + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          div_zero <= 1'b0;
          ovf      <= 1'b0;
        end
        FIX: begin
          div_zero <= dz_r;
          ovf      <= ovf_r;
          if (dz_r) begin
            quotient  <= op_dvd[2*BIT-1] ? Q_MIN : Q_MAX;
            remainder <= op_dvd[BIT-1:0];
          end else if (ovf_r) begin
            quotient  <= q_neg ? Q_MIN : Q_MAX;
            remainder <= op_dvd[BIT-1:0];
          end else begin
            quotient  <= q_fin;
            remainder <= r_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq_appr.sv
// Self-checking bench for divider_seq_appr: directed corner cases plus random operands against an arithmetic model.
// Define APPROX_DIV_EN to check the truncated-iteration build.
module tb_divider_seq_appr;

  localparam int BIT   = 16;
  localparam int TRUNC = 4;
`ifdef APPROX_DIV_EN
  localparam int N = BIT - TRUNC;
`else
  localparam int N = BIT;
`endif
  localparam int LAT = N + 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2*BIT-1:0]  dividend;
  logic [BIT-1:0]    divisor;
  logic              out_valid;
  logic              out_ready;
  logic [BIT-1:0]    quotient;
  logic [BIT-1:0]    remainder;
  logic              div_zero;
  logic              ovf;

  divider_seq_appr #(.BIT(BIT), .TRUNC(TRUNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] last_q, last_r;
  logic        last_dz, last_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed integer division with the saturation and divide-by-zero rules.
  function automatic void model(input logic [31:0] d_in, input logic [15:0] s_in,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic dz, output logic ov);
    longint dd, ds, qt, rt, ad, as_, qm;
    logic   nz;
    dd = longint'($signed(d_in));
    ds = longint'($signed(s_in));
    dz = 1'b0;
    ov = 1'b0;
    if (ds == 0) begin
      dz = 1'b1;
      q  = (dd >= 0) ? 16'h7FFF : 16'h8000;
      r  = d_in[15:0];
      return;
    end
    qt = dd / ds;
    rt = dd % ds;
    if (qt > 32767 || qt < -32768) begin
      ov = 1'b1;
      q  = (qt > 0) ? 16'h7FFF : 16'h8000;
      r  = d_in[15:0];
      return;
    end
`ifdef APPROX_DIV_EN
    ad = (dd < 0) ? -dd : dd;
    as_ = (ds < 0) ? -ds : ds;
    qm = ad / (as_ * (longint'(1) << TRUNC));
    nz = ((ad / (longint'(1) << TRUNC)) % as_) != 0;
    qm = qm * (longint'(1) << TRUNC) + (nz ? (longint'(1) << TRUNC) - 1 : 0);
    if ((dd < 0) != (ds < 0)) qm = -qm;
    q = qm[15:0];
    r = 16'h0000;
`else
    ad = 0; as_ = 0; qm = 0; nz = 1'b0;
    q = qt[15:0];
    r = rt[15:0];
`endif
  endfunction

  task automatic do_accept(input logic [31:0] d_in, input logic [15:0] s_in);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("accept_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    dividend = d_in;
    divisor  = s_in;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_in_ready", {31'b0, in_ready}, 32'd1);
    check("release_out_valid", {31'b0, out_valid}, 32'd0);
  endtask

  task automatic run_op(input logic [31:0] d_in, input logic [15:0] s_in, input logic early_ready);
    int          lat;
    logic [15:0] eq, er;
    logic        edz, eov;
    model(d_in, s_in, eq, er, edz, eov);
    do_accept(d_in, s_in);
    out_ready = early_ready;
    wait_done(lat);
    check("latency", lat, LAT);
    check("quotient", {16'b0, quotient}, {16'b0, eq});
    check("remainder", {16'b0, remainder}, {16'b0, er});
    check("div_zero", {31'b0, div_zero}, {31'b0, edz});
    check("ovf", {31'b0, ovf}, {31'b0, eov});
    last_q   = quotient;
    last_r   = remainder;
    last_dz  = div_zero;
    last_ovf = ovf;
    release_result();
  endtask

  initial begin
    int          lat;
    logic [15:0] eq, er;
    logic        edz, eov;
    logic [31:0] rd;
    logic [15:0] rs, rq;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_quotient", {16'b0, quotient}, 32'd0);
    check("rst_remainder", {16'b0, remainder}, 32'd0);
    check("rst_flags", {30'b0, div_zero, ovf}, 32'd0);
    rst_n = 1'b1;

    run_op(32'd100, 16'd7, 1'b0);
`ifdef APPROX_DIV_EN
    check("t6_q", {16'b0, last_q}, 32'h000F);
    check("t6_r", {16'b0, last_r}, 32'h0000);
    run_op(32'd112, 16'd7, 1'b0);
`else
    check("t1_q", {16'b0, last_q}, 32'h000E);
    check("t1_r", {16'b0, last_r}, 32'h0002);
    run_op(-32'sd100, 16'd7, 1'b0);
    check("t2a_q", {16'b0, last_q}, 32'hFFF2);
    check("t2a_r", {16'b0, last_r}, 32'hFFFE);
    run_op(32'd100, -16'sd7, 1'b0);
    check("t2b_q", {16'b0, last_q}, 32'hFFF2);
    check("t2b_r", {16'b0, last_r}, 32'h0002);
`endif

    run_op(32'd1234, 16'd0, 1'b0);
    check("t3a_dz", {31'b0, last_dz}, 32'd1);
    check("t3a_q", {16'b0, last_q}, 32'h7FFF);
    check("t3a_r", {16'b0, last_r}, 32'h04D2);
    run_op(32'h0001_0000, 16'd1, 1'b0);
    check("t3b_ovf", {31'b0, last_ovf}, 32'd1);
    check("t3b_q", {16'b0, last_q}, 32'h7FFF);
    run_op(32'hFFFF_8000, 16'd1, 1'b0);
    check("t3c_ovf", {31'b0, last_ovf}, 32'd0);
    check("t3c_q", {16'b0, last_q}, 32'h8000);

    // Zero dividend, most-negative operands and the saturation edges.
    run_op(32'd0, 16'd5, 1'b0);
    run_op(32'd0, 16'hFFFB, 1'b0);
    run_op(32'hFFFF_FFF0, 16'd0, 1'b0);
    run_op(32'h8000_0000, 16'hFFFF, 1'b0);
    run_op(32'hC000_0000, 16'h8000, 1'b0);
    run_op(32'h3FFF_8000, 16'h8000, 1'b0);
    run_op(32'h0000_7FFF, 16'd1, 1'b1);

    // Result held under back-pressure while in_valid pulses are ignored.
    model(32'd500, 16'hFFFD, eq, er, edz, eov);
    do_accept(32'd500, 16'hFFFD);
    wait_done(lat);
    check("hold_latency", lat, LAT);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      dividend = $urandom;
      divisor  = 16'($urandom);
      @(negedge clk);
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      check("hold_quotient", {16'b0, quotient}, {16'b0, eq});
      check("hold_remainder", {16'b0, remainder}, {16'b0, er});
      check("hold_flags", {30'b0, div_zero, ovf}, {30'b0, edz, eov});
    end
    in_valid = 1'b0;
    release_result();

    // Synchronous reset in the middle of the iterations.
    do_accept(32'd1234, 16'd5);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_quotient", {16'b0, quotient}, 32'd0);
    check("abort_remainder", {16'b0, remainder}, 32'd0);
    check("abort_flags", {30'b0, div_zero, ovf}, 32'd0);
    rst_n = 1'b1;
    run_op(32'd100, 16'd7, 1'b0);
`ifndef APPROX_DIV_EN
    check("t5_q", {16'b0, last_q}, 32'h000E);
    check("t5_r", {16'b0, last_r}, 32'h0002);
`endif

    // Random operands: full-range, sign-extended and product-shaped dividends.
    for (int i = 0; i < 60; i++) begin
      rs = 16'($urandom);
      if ($urandom_range(0, 9) == 0) rs = 16'h0000;
      case ($urandom_range(0, 2))
        0: rd = $urandom;
        1: rd = {{16{rs[15] ^ 1'b1}}, 16'($urandom)};
        default: begin
          rq = 16'($urandom);
          rd = 32'($signed(rs) * $signed(rq)) + 32'($urandom_range(0, 3));
        end
      endcase
      run_op(rd, rs, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
